// File: rtl/udp_bridge_pkg.sv
// Shared definitions for the UDP bridge receive path.
//   - CRC-32 constants (polynomial, init value, good-frame residue)
//   - RMII preamble / SFD dibit codes
//   - bit positions inside the out_error vector
//   - receive deframer state encoding
//   - helper to pick one byte of a MAC address in wire order
package udp_bridge_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    // Register value after DA..FCS of a good frame, with the register
    // kept in non-reflected order and fed bits in wire order.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;

    localparam int ERR_CRC  = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DISCARD,
        END
    } rx_state_e;

    // Byte idx (0 = first on the wire) of a MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_crc32_d2.sv
// CRC-32 accumulator advancing two bits per clock.
// Ports:
//   clk_clk      clock
//   reset_reset  synchronous active-high reset (register returns to init)
//   crc_init     load the init value (wins over crc_en)
//   crc_en       fold dibit into the register
//   dibit        two data bits, [0] is first on the wire
//   crc_value    current register value
module eth_crc32_d2
    import udp_bridge_pkg::*;
(
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        crc_init,
    input  logic        crc_en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_value
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_next;

    // Non-reflected shift-left form; equivalent to the reflected
    // LSB-first Ethernet CRC with the register bit-reversed.
    always_comb begin
        crc_next = crc_q;
        for (int i = 0; i < 2; i++) begin
            crc_next = {crc_next[30:0], 1'b0}
                     ^ ((crc_next[31] ^ dibit[i]) ? CRC32_POLY : 32'h0);
        end
    end

    always_comb begin
        crc_d = crc_q;
        if (crc_init) begin
            crc_d = CRC32_INIT;
        end else if (crc_en) begin
            crc_d = crc_next;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_value = crc_q;

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: dibits -> bytes, strips preamble/SFD/FCS,
// checks CRC-32, length and destination MAC, and drives an Avalon-ST
// source with the error status on the end-of-packet beat.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for carrier with a preamble dibit
// PREAMBLE | inside preamble, looking for the SFD tail dibit
// DATA     | assembling bytes, delay line feeding the output
// DISCARD  | receive disabled at SFD, waiting for carrier to drop
// END      | last payload byte on the output, then back to IDLE
//
// Ports:
//   clk_clk, reset_reset      clock and synchronous active-high reset
//   ethio_enable              receive enable, sampled at SFD
//   macaddr_value             own MAC, [47:40] first on the wire
//   rmii_rxd, rmii_crs_dv     RMII receive interface
//   out_data/valid/sop/eop    Avalon-ST byte stream, no backpressure
//   out_error                 [0] CRC, [1] length/alignment, [2] address
//   stat_frame, stat_drop     per-frame delivered / discarded pulses
module rmii_rx_deframer
    import udp_bridge_pkg::*;
#(
    parameter int FRAME_MIN = 64,
    parameter int FRAME_MAX = 1518,
    parameter bit PROMISC   = 1'b0
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              ethio_enable,
    input  logic [47:0]       macaddr_value,
    input  logic [1:0]        rmii_rxd,
    input  logic              rmii_crs_dv,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [ERR_W-1:0]  out_error,
    output logic              stat_frame,
    output logic              stat_drop
);

    localparam logic [10:0] MIN_LEN = 11'(FRAME_MIN);
    localparam logic [10:0] MAX_LEN = 11'(FRAME_MAX);
    localparam logic [10:0] CNT_SAT = 11'h7FF;

    rx_state_e        state_q,      state_d;
    logic [1:0]       phase_q,      phase_d;
    logic [7:0]       byte_sr_q,    byte_sr_d;
    logic [4:0][7:0]  dline_q,      dline_d;
    logic [10:0]      byte_cnt_q,   byte_cnt_d;
    logic [47:0]      mac_q,        mac_d;
    logic             da_own_q,     da_own_d;
    logic             da_bc_q,      da_bc_d;
    logic [7:0]       out_data_q,   out_data_d;
    logic             out_valid_q,  out_valid_d;
    logic             out_sop_q,    out_sop_d;
    logic             out_eop_q,    out_eop_d;
    logic [ERR_W-1:0] out_error_q,  out_error_d;
    logic             stat_frame_q, stat_frame_d;
    logic             stat_drop_q,  stat_drop_d;

    logic             crc_init;
    logic             crc_en;
    logic [31:0]      crc_value;
    logic [7:0]       new_byte;
    logic             len_bad;

    eth_crc32_d2 u_crc (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .crc_init    (crc_init),
        .crc_en      (crc_en),
        .dibit       (rmii_rxd),
        .crc_value   (crc_value)
    );

    assign new_byte = {rmii_rxd, byte_sr_q[7:2]};
    assign len_bad  = (byte_cnt_q < MIN_LEN) || (byte_cnt_q > MAX_LEN);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        byte_sr_d    = byte_sr_q;
        dline_d      = dline_q;
        byte_cnt_d   = byte_cnt_q;
        mac_d        = mac_q;
        da_own_d     = da_own_q;
        da_bc_d      = da_bc_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_sop_d    = 1'b0;
        out_eop_d    = 1'b0;
        out_error_d  = '0;
        stat_frame_d = 1'b0;
        stat_drop_d  = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rmii_crs_dv && rmii_rxd == PREAMBLE_DIBIT) begin
                    state_d = PREAMBLE;
                end
            end

            PREAMBLE: begin
                if (!rmii_crs_dv) begin
                    state_d = IDLE;
                end else if (rmii_rxd == SFD_DIBIT) begin
                    phase_d    = 2'd0;
                    byte_cnt_d = '0;
                    mac_d      = macaddr_value;
                    da_own_d   = 1'b1;
                    da_bc_d    = 1'b1;
                    crc_init   = 1'b1;
                    state_d    = ethio_enable ? DATA : DISCARD;
                end else if (rmii_rxd != PREAMBLE_DIBIT) begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                // Carrier is only meaningful on even phases; odd-phase
                // drops are the RMII CRS toggle near end of frame.
                if (!phase_q[0] && !rmii_crs_dv) begin
                    state_d = END;
                    if (byte_cnt_q > 11'd5) begin
                        // May directly follow the previous beat when the
                        // frame ends right after a byte boundary.
                        out_valid_d           = 1'b1;
                        out_eop_d             = 1'b1;
                        out_data_d            = dline_q[4];
                        out_error_d[ERR_CRC]  = (crc_value != CRC32_RESIDUE);
                        out_error_d[ERR_LEN]  = len_bad | phase_q[1];
                        out_error_d[ERR_ADDR] = !PROMISC && !da_own_q && !da_bc_q;
                        stat_frame_d          = 1'b1;
                    end else begin
                        stat_drop_d = 1'b1;
                    end
                end else begin
                    crc_en    = 1'b1;
                    byte_sr_d = new_byte;
                    phase_d   = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        dline_d = {dline_q[3:0], new_byte};
                        if (byte_cnt_q != CNT_SAT) begin
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end
                        if (byte_cnt_q < 11'd6) begin
                            if (new_byte != mac_byte(mac_q, byte_cnt_q[2:0])) begin
                                da_own_d = 1'b0;
                            end
                            if (new_byte != 8'hFF) begin
                                da_bc_d = 1'b0;
                            end
                        end
                        // Five bytes stay held back so the FCS never
                        // reaches the output.
                        if (byte_cnt_q >= 11'd5) begin
                            out_valid_d = 1'b1;
                            out_data_d  = dline_q[4];
                            out_sop_d   = (byte_cnt_q == 11'd5);
                        end
                    end
                end
            end

            DISCARD: begin
                phase_d = phase_q + 2'd1;
                if (!phase_q[0] && !rmii_crs_dv) begin
                    stat_drop_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            END: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            byte_sr_q    <= '0;
            dline_q      <= '0;
            byte_cnt_q   <= '0;
            mac_q        <= '0;
            da_own_q     <= 1'b0;
            da_bc_q      <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_error_q  <= '0;
            stat_frame_q <= 1'b0;
            stat_drop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            byte_sr_q    <= byte_sr_d;
            dline_q      <= dline_d;
            byte_cnt_q   <= byte_cnt_d;
            mac_q        <= mac_d;
            da_own_q     <= da_own_d;
            da_bc_q      <= da_bc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_error_q  <= out_error_d;
            stat_frame_q <= stat_frame_d;
            stat_drop_q  <= stat_drop_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_error  = out_error_q;
    assign stat_frame = stat_frame_q;
    assign stat_drop  = stat_drop_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer. Two instances share the RMII
// inputs: u_dut with PROMISC=0 and u_dut_p with PROMISC=1.
module tb_rmii_rx_deframer;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        ethio_enable = 1'b1;
    logic [47:0] macaddr_value = 48'h0011_2233_4455;
    logic [1:0]  rmii_rxd = 2'b00;
    logic        rmii_crs_dv = 1'b0;

    logic [7:0]  out_data;
    logic        out_valid, out_sop, out_eop, stat_frame, stat_drop;
    logic [2:0]  out_error;
    logic [7:0]  p_out_data;
    logic        p_out_valid, p_out_sop, p_out_eop, p_stat_frame, p_stat_drop;
    logic [2:0]  p_out_error;

    always #10 clk_clk = ~clk_clk;

    rmii_rx_deframer #(.FRAME_MIN(64), .FRAME_MAX(1518), .PROMISC(1'b0)) u_dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .ethio_enable(ethio_enable),
        .macaddr_value(macaddr_value), .rmii_rxd(rmii_rxd), .rmii_crs_dv(rmii_crs_dv),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_error(out_error), .stat_frame(stat_frame), .stat_drop(stat_drop)
    );

    rmii_rx_deframer #(.FRAME_MIN(64), .FRAME_MAX(1518), .PROMISC(1'b1)) u_dut_p (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .ethio_enable(ethio_enable),
        .macaddr_value(macaddr_value), .rmii_rxd(rmii_rxd), .rmii_crs_dv(rmii_crs_dv),
        .out_data(p_out_data), .out_valid(p_out_valid), .out_sop(p_out_sop), .out_eop(p_out_eop),
        .out_error(p_out_error), .stat_frame(p_stat_frame), .stat_drop(p_stat_drop)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] tx [0:2047];
    int         tx_len = 0;

    logic [7:0] cap_data [0:2047];
    int         cap_n = 0;
    int         sop_cnt = 0, sop_idx = -1;
    int         eop_cnt = 0, eop_idx = -1;
    logic [2:0] eop_err = 3'b000;
    int         nframe = 0, ndrop = 0;
    int         p_n = 0, p_diff = 0;
    logic [2:0] p_err = 3'b000;

    always @(negedge clk_clk) begin
        if (reset_reset !== 1'b1) begin
            if (out_valid) begin
                if (cap_n < 2048) cap_data[cap_n] = out_data;
                if (out_sop) begin sop_cnt++; sop_idx = cap_n; end
                if (out_eop) begin eop_cnt++; eop_idx = cap_n; eop_err = out_error; end
                cap_n++;
            end
            if (stat_frame) nframe++;
            if (stat_drop) ndrop++;
            if (p_out_valid) begin
                p_n++;
                if (p_out_eop) p_err = p_out_error;
            end
            if ({p_out_valid, p_out_data, p_out_sop, p_out_eop, p_stat_frame, p_stat_drop} !==
                {out_valid, out_data, out_sop, out_eop, stat_frame, stat_drop})
                p_diff++;
        end
    end

    task automatic clear_cap();
        cap_n = 0; sop_cnt = 0; sop_idx = -1; eop_cnt = 0; eop_idx = -1;
        eop_err = 3'b000; nframe = 0; ndrop = 0; p_n = 0; p_diff = 0; p_err = 3'b000;
    endtask

    task automatic drive(input logic dv, input logic [1:0] d);
        @(posedge clk_clk);
        #1;
        rmii_crs_dv = dv;
        rmii_rxd    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
    endtask

    // Standard reflected Ethernet CRC-32 over tx[0..n-1], final value inverted.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int len);
        logic [47:0] sa;
        logic [31:0] fcs;
        sa = 48'h02AA_BBCC_DDEE;
        for (int i = 0; i < 6; i++) begin
            tx[i]     = da[47-8*i -: 8];
            tx[6 + i] = sa[47-8*i -: 8];
        end
        tx[12] = 8'h08;
        tx[13] = 8'h00;
        for (int i = 14; i < len - 4; i++) tx[i] = 8'(i * 7 + 3);
        fcs = fcs_of(len - 4);
        for (int k = 0; k < 4; k++) tx[len - 4 + k] = fcs[8*k +: 8];
        tx_len = len;
    endtask

    // Preamble + SFD, then tx[] LSB-first. toggle_tail drops crs_dv on odd
    // phases of the last 8 bytes; extra appends dibits after the last byte;
    // reset_after>0 pulses reset once that many beats have been seen.
    task automatic send_frame(input bit toggle_tail, input int extra, input int reset_after);
        logic [7:0] b;
        bit aborted;
        logic dv;
        aborted = 1'b0;
        for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int i = 0; i < tx_len; i++) begin
            for (int p = 0; p < 4; p++) begin
                if (!aborted) begin
                    if (reset_after > 0 && cap_n >= reset_after) begin
                        aborted = 1'b1;
                        @(posedge clk_clk);
                        #1;
                        reset_reset = 1'b1;
                        rmii_crs_dv = 1'b0;
                        rmii_rxd    = 2'b00;
                        repeat (3) @(posedge clk_clk);
                        #1;
                        reset_reset = 1'b0;
                    end else begin
                        b  = tx[i];
                        dv = !(toggle_tail && (i >= tx_len - 8) && (p % 2 == 1));
                        drive(dv, b[2*p +: 2]);
                    end
                end
            end
        end
        if (!aborted)
            for (int i = 0; i < extra; i++) drive(1'b1, 2'b10);
        idle(24);
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        repeat (4) @(posedge clk_clk);
        @(negedge clk_clk);
        checks++;
        if ({out_data, out_valid, out_sop, out_eop, out_error, stat_frame, stat_drop} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {out_data, out_valid, out_sop, out_eop, out_error, stat_frame, stat_drop});
        end
        checks++;
        if ({p_out_data, p_out_valid, p_out_sop, p_out_eop, p_out_error, p_stat_frame, p_stat_drop} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs_p: got %h expected 0", {p_out_data, p_out_valid, p_out_sop, p_out_eop, p_out_error, p_stat_frame, p_stat_drop});
        end
        #1;
        reset_reset = 1'b0;
        idle(6);
        @(negedge clk_clk);
        checks++;
        if ({out_valid, out_eop, stat_frame, stat_drop} !== 4'h0) begin
            failures++;
            $display("FAIL post_reset_quiet: got %b expected 0000", {out_valid, out_eop, stat_frame, stat_drop});
        end
    endtask

    task automatic test_good_64();
        int bad;
        clear_cap();
        build_frame(48'h0011_2233_4455, 64);
        send_frame(1'b0, 0, 0);
        bad = 0;
        for (int j = 0; j < cap_n && j < 2048; j++) if (cap_data[j] !== tx[j]) bad++;
        checks++; if (cap_n !== 60) begin failures++; $display("FAIL good64_beats: got %0d expected 60", cap_n); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL good64_data: got %0d bad bytes expected 0", bad); end
        checks++; if (cap_data[0] !== 8'h00) begin failures++; $display("FAIL good64_first: got %h expected 00", cap_data[0]); end
        checks++; if (sop_cnt !== 1 || sop_idx !== 0) begin failures++; $display("FAIL good64_sop: got cnt %0d idx %0d expected 1/0", sop_cnt, sop_idx); end
        checks++; if (eop_cnt !== 1 || eop_idx !== 59) begin failures++; $display("FAIL good64_eop: got cnt %0d idx %0d expected 1/59", eop_cnt, eop_idx); end
        checks++; if (eop_err !== 3'b000) begin failures++; $display("FAIL good64_err: got %b expected 000", eop_err); end
        checks++; if (nframe !== 1 || ndrop !== 0) begin failures++; $display("FAIL good64_stat: got frame %0d drop %0d expected 1/0", nframe, ndrop); end
    endtask

    task automatic test_crc_error();
        int bad;
        clear_cap();
        build_frame(48'h0011_2233_4455, 64);
        tx[30] = tx[30] ^ 8'h10;
        send_frame(1'b0, 0, 0);
        bad = 0;
        for (int j = 0; j < cap_n && j < 2048; j++) if (cap_data[j] !== tx[j]) bad++;
        checks++; if (cap_n !== 60) begin failures++; $display("FAIL crc_beats: got %0d expected 60", cap_n); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL crc_data: got %0d bad bytes expected 0", bad); end
        checks++; if (eop_err !== 3'b001) begin failures++; $display("FAIL crc_err: got %b expected 001", eop_err); end
    endtask

    task automatic test_address();
        clear_cap();
        build_frame(48'hFFFF_FFFF_FFFF, 100);
        send_frame(1'b0, 0, 0);
        checks++; if (cap_n !== 96) begin failures++; $display("FAIL bcast_beats: got %0d expected 96", cap_n); end
        checks++; if (eop_err !== 3'b000) begin failures++; $display("FAIL bcast_err: got %b expected 000", eop_err); end

        clear_cap();
        build_frame(48'h0200_0000_0001, 100);
        send_frame(1'b0, 0, 0);
        checks++; if (cap_n !== 96) begin failures++; $display("FAIL other_beats: got %0d expected 96", cap_n); end
        checks++; if (eop_err !== 3'b100) begin failures++; $display("FAIL other_err: got %b expected 100", eop_err); end
        checks++; if (p_n !== 96 || p_err !== 3'b000) begin failures++; $display("FAIL promisc_err: got beats %0d err %b expected 96/000", p_n, p_err); end
        checks++; if (p_diff !== 0) begin failures++; $display("FAIL promisc_stream: got %0d differing cycles expected 0", p_diff); end
    endtask

    task automatic test_short_len();
        clear_cap();
        build_frame(48'h0011_2233_4455, 40);
        send_frame(1'b0, 0, 0);
        checks++; if (cap_n !== 36) begin failures++; $display("FAIL len40_beats: got %0d expected 36", cap_n); end
        checks++; if (eop_idx !== 35) begin failures++; $display("FAIL len40_eop: got %0d expected 35", eop_idx); end
        checks++; if (eop_err !== 3'b010) begin failures++; $display("FAIL len40_err: got %b expected 010", eop_err); end
    endtask

    task automatic test_fragment();
        clear_cap();
        tx[0] = 8'hDE; tx[1] = 8'hAD; tx[2] = 8'hBE; tx[3] = 8'hEF;
        tx_len = 4;
        send_frame(1'b0, 0, 0);
        checks++; if (cap_n !== 0) begin failures++; $display("FAIL frag_beats: got %0d expected 0", cap_n); end
        checks++; if (ndrop !== 1 || nframe !== 0) begin failures++; $display("FAIL frag_stat: got drop %0d frame %0d expected 1/0", ndrop, nframe); end
    endtask

    task automatic test_align();
        clear_cap();
        build_frame(48'h0011_2233_4455, 64);
        send_frame(1'b0, 2, 0);
        checks++; if (cap_n !== 60 || eop_idx !== 59) begin failures++; $display("FAIL align_beats: got %0d eop %0d expected 60/59", cap_n, eop_idx); end
        checks++; if (eop_err[1] !== 1'b1) begin failures++; $display("FAIL align_err: got %b expected 1", eop_err[1]); end
        checks++; if (nframe !== 1) begin failures++; $display("FAIL align_stat: got %0d expected 1", nframe); end
    endtask

    task automatic test_crs_toggle();
        int bad;
        clear_cap();
        build_frame(48'h0011_2233_4455, 64);
        send_frame(1'b1, 0, 0);
        bad = 0;
        for (int j = 0; j < cap_n && j < 2048; j++) if (cap_data[j] !== tx[j]) bad++;
        checks++; if (cap_n !== 60 || eop_idx !== 59) begin failures++; $display("FAIL toggle_beats: got %0d eop %0d expected 60/59", cap_n, eop_idx); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL toggle_data: got %0d bad bytes expected 0", bad); end
        checks++; if (eop_err !== 3'b000) begin failures++; $display("FAIL toggle_err: got %b expected 000", eop_err); end
    endtask

    task automatic test_disabled();
        clear_cap();
        ethio_enable = 1'b0;
        build_frame(48'h0011_2233_4455, 64);
        send_frame(1'b0, 0, 0);
        ethio_enable = 1'b1;
        checks++; if (cap_n !== 0) begin failures++; $display("FAIL disabled_beats: got %0d expected 0", cap_n); end
        checks++; if (ndrop !== 1 || nframe !== 0) begin failures++; $display("FAIL disabled_stat: got drop %0d frame %0d expected 1/0", ndrop, nframe); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        clear_cap();
        build_frame(48'h0011_2233_4455, 64);
        send_frame(1'b0, 0, 20);
        checks++; if (eop_cnt !== 0) begin failures++; $display("FAIL rstmid_eop: got %0d expected 0", eop_cnt); end
        checks++; if (nframe !== 0 || ndrop !== 0) begin failures++; $display("FAIL rstmid_stat: got frame %0d drop %0d expected 0/0", nframe, ndrop); end
        clear_cap();
        send_frame(1'b0, 0, 0);
        bad = 0;
        for (int j = 0; j < cap_n && j < 2048; j++) if (cap_data[j] !== tx[j]) bad++;
        checks++; if (cap_n !== 60 || bad !== 0) begin failures++; $display("FAIL rstmid_next: got beats %0d bad %0d expected 60/0", cap_n, bad); end
        checks++; if (eop_err !== 3'b000 || nframe !== 1) begin failures++; $display("FAIL rstmid_next_status: got err %b frame %0d expected 000/1", eop_err, nframe); end
    endtask

    initial begin
        test_reset();
        test_good_64();
        test_crc_error();
        test_address();
        test_short_len();
        test_fragment();
        test_align();
        test_crs_toggle();
        test_disabled();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
